// File: rtl/jtpopeye_pkg.sv
// Shared timing defaults, scroll register map and scroll register bundle
// for the raster timer.
package jtpopeye_pkg;

   localparam int DEF_HTOTAL   = 384;
   localparam int DEF_HACTIVE  = 256;
   localparam int DEF_HS_START = 288;
   localparam int DEF_HS_LEN   = 32;
   localparam int DEF_VTOTAL   = 264;
   localparam int DEF_VACTIVE  = 224;
   localparam int DEF_VS_START = 240;
   localparam int DEF_VS_LEN   = 4;

   localparam logic [1:0] SCRX = 2'd0;
   localparam logic [1:0] SCRY = 2'd1;
   localparam logic [1:0] FLIP = 2'd2;

   typedef struct packed {
      logic [7:0] scrx;
      logic [7:0] scry;
      logic       flip;
   } scroll_t;

endpackage

// File: rtl/jtpopeye_vtimer_scroll_regs.sv
// CPU-visible scroll/flip shadow registers and the active copy that the
// raster logic uses, reloaded as one unit at the start of vblank.
module jtpopeye_scroll_regs
   import jtpopeye_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       xfer,
   input  logic       cpu_cen,
   input  logic       scr_we,
   input  logic [1:0] scr_addr,
   input  logic [7:0] cpu_dout,
   output scroll_t    act
);

   scroll_t shd_q, shd_d;
   scroll_t act_q, act_d;

   // Transfer reads shd_q, so a write landing on the same clk waits a frame.
   always_comb begin
      shd_d = shd_q;
      act_d = act_q;
      if (xfer) act_d = shd_q;
      if (cpu_cen && scr_we) begin
         case (scr_addr)
            SCRX:    shd_d.scrx = cpu_dout;
            SCRY:    shd_d.scry = cpu_dout;
            FLIP:    shd_d.flip = cpu_dout[0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shd_q <= '0;
         act_q <= '0;
      end else begin
         shd_q <= shd_d;
         act_q <= act_d;
      end
   end

   assign act = act_q;

endmodule

// File: rtl/jtpopeye_vtimer.sv
// Raster timing generator: H/V counters, blanking, sync and the scrolled
// background coordinates handed to the tile stage.
module jtpopeye_vtimer
   import jtpopeye_pkg::*;
#(
   parameter int HTOTAL   = DEF_HTOTAL,
   parameter int HACTIVE  = DEF_HACTIVE,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_LEN   = DEF_HS_LEN,
   parameter int VTOTAL   = DEF_VTOTAL,
   parameter int VACTIVE  = DEF_VACTIVE,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_LEN   = DEF_VS_LEN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pxl_cen,
   input  logic       cpu_cen,
   input  logic       scr_we,
   input  logic [1:0] scr_addr,
   input  logic [7:0] cpu_dout,
   output logic [8:0] H,
   output logic [8:0] V,
   output logic       LHBL,
   output logic       LVBL,
   output logic       HS,
   output logic       VS,
   output logic [8:0] ROVI,
   output logic [7:0] ROH,
   output logic       flip
);

   localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
   localparam logic [8:0] H_ACT  = 9'(HACTIVE);
   localparam logic [8:0] V_ACT  = 9'(VACTIVE);
   localparam logic [8:0] V_XFER = 9'(VACTIVE - 1);
   localparam logic [8:0] HS_S   = 9'(HS_START);
   localparam logic [8:0] HS_E   = 9'(HS_START + HS_LEN);
   localparam logic [8:0] VS_S   = 9'(VS_START);
   localparam logic [8:0] VS_E   = 9'(VS_START + VS_LEN);

   logic [8:0] h_q, h_d, v_q, v_d, rovi_q, rovi_d;
   logic [7:0] roh_q, roh_d;
   logic       lhbl_q, lhbl_d, lvbl_q, lvbl_d, hs_q, hs_d, vs_q, vs_d;
   logic       xfer;
   logic [7:0] sum_h;
   logic [8:0] sum_v;
   scroll_t    act;

   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      lhbl_d = lhbl_q;
      lvbl_d = lvbl_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      roh_d  = roh_q;
      rovi_d = rovi_q;
      xfer   = 1'b0;
      sum_h  = h_q[7:0] + act.scrx;
      sum_v  = v_q + {1'b0, act.scry};
      if (pxl_cen) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
         end else begin
            h_d = h_q + 9'd1;
         end
         // Blank/sync decode the new count so they line up with H/V.
         lhbl_d = h_d < H_ACT;
         lvbl_d = v_d < V_ACT;
         hs_d   = (h_d >= HS_S) && (h_d < HS_E);
         vs_d   = (v_d >= VS_S) && (v_d < VS_E);
         // Scroll sums use the old count, giving the one-pixel lag.
         roh_d  = act.flip ? ~sum_h : sum_h;
         rovi_d = act.flip ? {sum_v[8], ~sum_v[7:0]} : sum_v;
         xfer   = (h_q == H_LAST) && (v_q == V_XFER);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q    <= '0;
         v_q    <= '0;
         lhbl_q <= 1'b1;
         lvbl_q <= 1'b1;
         hs_q   <= 1'b0;
         vs_q   <= 1'b0;
         roh_q  <= '0;
         rovi_q <= '0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         lhbl_q <= lhbl_d;
         lvbl_q <= lvbl_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         roh_q  <= roh_d;
         rovi_q <= rovi_d;
      end
   end

   jtpopeye_scroll_regs u_regs (
      .clk      (clk),
      .rst      (rst),
      .xfer     (xfer),
      .cpu_cen  (cpu_cen),
      .scr_we   (scr_we),
      .scr_addr (scr_addr),
      .cpu_dout (cpu_dout),
      .act      (act)
   );

   assign H    = h_q;
   assign V    = v_q;
   assign LHBL = lhbl_q;
   assign LVBL = lvbl_q;
   assign HS   = hs_q;
   assign VS   = vs_q;
   assign ROH  = roh_q;
   assign ROVI = rovi_q;
   assign flip = act.flip;

endmodule

// File: doc/jtpopeye_vtimer.md
Name: jtpopeye_vtimer

Overview:
- Generates the raster timing (H/V counters, blanking, sync) for the video path.
- Produces the scrolled background coordinates ROVI/ROH that the background tile stage consumes.
- Holds CPU-written scroll and flip registers, double-buffered so their values only change during vertical blanking.
- Sits directly upstream of the background stage; its blanking outputs also drive the colour mixer.

Parameters:
- HTOTAL, 384, pixels per line (counter 0..HTOTAL-1)
- HACTIVE, 256, visible pixels per line (H 0..HACTIVE-1)
- HS_START, 288, H value at which HS asserts
- HS_LEN, 32, HS width in pixels
- VTOTAL, 264, lines per frame
- VACTIVE, 224, visible lines (V 0..VACTIVE-1)
- VS_START, 240, V value at which VS asserts
- VS_LEN, 4, VS width in lines

Ports:
- clk input 1 system clock
- rst input 1 synchronous reset, active-high
- pxl_cen input 1 pixel clock enable; all timing advances only on it
- cpu_cen input 1 CPU clock enable; register writes are sampled only on it
- scr_we input 1 scroll/flip register write strobe, active-high
- scr_addr input 2 register select: 0 scroll X, 1 scroll Y, 2 flip (bit 0), 3 ignored
- cpu_dout input 8 CPU write data
- H output 9 raw horizontal counter
- V output 9 raw vertical counter
- LHBL output 1 horizontal blank, active-low (1 while H<HACTIVE)
- LVBL output 1 vertical blank, active-low (1 while V<VACTIVE)
- HS output 1 horizontal sync, active-high
- VS output 1 vertical sync, active-high
- ROVI output 9 scrolled vertical coordinate to the background stage
- ROH output 8 scrolled horizontal coordinate to the background stage
- flip output 1 active flip state

Behaviour:
- Reset:
  - H=0, V=0, LHBL=1, LVBL=1, HS=0, VS=0, ROVI=0, ROH=0, flip=0.
  - All shadow and active scroll registers = 0.
  - Reset applied mid-frame restarts the frame at H=0, V=0 on the next clk.
- Counters, per pxl_cen:
  - H increments; H==HTOTAL-1 wraps to 0 and increments V.
  - V==VTOTAL-1 with H wrap sets V=0.
  - Without pxl_cen, every register holds.
- Blank and sync: registered, same cycle as the counters, so each is a pure function of the current H/V.
  - LHBL = H<HACTIVE
  - LVBL = V<VACTIVE
  - HS = H in [HS_START, HS_START+HS_LEN)
  - VS = V in [VS_START, VS_START+VS_LEN)
- CPU writes:
  - On cpu_cen & scr_we, cpu_dout goes to the shadow register selected by scr_addr; addr 3 is a no-op.
  - Writes are accepted at any time and never disturb the active values directly.
- Shadow to active transfer:
  - Happens on the pxl_cen where the counters move to H=0, V=VACTIVE (start of vblank).
  - All three registers (scroll X, scroll Y, flip) copy together.
  - If a CPU write and the transfer coincide in the same clk, the transfer takes the old shadow value; the new value lands at the next vblank.
- Scroll arithmetic: registered one pxl_cen after H/V, so ROH/ROVI lag H/V by exactly 1 pixel.
  - ROVI = (V + {1'b0, scry}) mod 512
  - ROH = (H[7:0] + scrx) mod 256, wrapping with no carry
  - flip=1: ROH = ~(H[7:0] + scrx), ROVI[7:0] = ~(V[7:0] + scry), ROVI[8] unchanged.
- Blanking intervals: ROH/ROVI keep being computed; downstream masks them with LHBL/LVBL.
- Frame length: exactly HTOTAL*VTOTAL pxl_cen pulses.

Decomposition:
- Shared package jtpopeye_pkg:
  - default timing constants (HTOTAL..VS_LEN)
  - scroll register address localparams (SCRX=0, SCRY=1, FLIP=2)
- One natural sub-module, jtpopeye_scroll_regs: shadow/active registers and the vblank transfer.
- The counter, blank/sync and arithmetic logic stay in the top module.

Test Plan:
- Reset release, free run of one full frame:
  - 384*264 = 101376 pxl_cen to return to H=0, V=0.
  - LHBL low for 128 px per line; LVBL low for 40 lines; HS high H=288..319; VS high V=240..243.
- Write scrx=0x10, scry=0x05 mid-frame at V=100:
  - ROH/ROVI unchanged until the vblank transfer.
  - Next frame at H=0, V=0: ROH=0x10, ROVI=0x005 one pxl_cen later.
- Wrap:
  - scrx=0xF8: H=8 gives ROH=0x00.
  - scry=0xFF: V=263 gives ROVI=(263+255) mod 512=0x006.
- Flip:
  - Write addr 2 data 0x01, wait for vblank, scroll 0.
  - H=0, V=0 gives ROH=0xFF, ROVI=0x0FF; flip output=1.
- Write coincident with the transfer clk:
  - scrx shadow 0x20, new write 0x30 on the same clk.
  - Active=0x20 for that frame, 0x30 after the following vblank.
- Assert rst at H=200, V=150 for one clk with stale scroll values:
  - Outputs return to reset values; scroll registers cleared; counting resumes from 0,0.
  - A write on addr 3 leaves all registers unchanged.
